// File: rtl/li_credit_source.sv
// rtl/li_credit_source.sv - credit-gated arithmetic sample source with run/pause/done control
module li_credit_source #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_ADDR  = 4,
  parameter int NUM_WORDS  = 1024,
  parameter int SEED       = 0,
  parameter int STEP       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_li_feedback,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_done,
  output logic [31:0]           o_count,
  output logic [FIFO_ADDR:0]    o_credits,
  output logic                  o_credit_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SEED_V      = DATA_WIDTH'(SEED);
  localparam logic [DATA_WIDTH-1:0] STEP_V      = DATA_WIDTH'(STEP);
  localparam bit                    RUN_FOREVER = (NUM_WORDS == 0);
  localparam logic [31:0]           LAST_IDX    = 32'(NUM_WORDS - 1);
  localparam logic [FIFO_ADDR:0]    MAX_CREDITS = {1'b1, {FIFO_ADDR{1'b0}}};

  state_t                  state_q;
  state_t                  state_d;
  logic                    rst_meta;
  logic                    rst_sync;
  logic                    active;
  logic                    issue;
  logic                    run_entry;
  logic                    credit_ret;
  logic [DATA_WIDTH-1:0]   value_q;

  // Two-flop synchroniser on reset release; logic stays frozen until it reports ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign active     = rst_sync;
  assign credit_ret = active & i_li_feedback;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, issue decision and run-entry strobe
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    run_entry = 1'b0;
    if (active) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_d   = ST_RUN;
            run_entry = 1'b1;
          end
        end
        ST_RUN: begin
          // Issue uses the credit count as it stood before this edge
          if ((o_credits != '0) && !i_pause) begin
            issue = 1'b1;
            if (!RUN_FOREVER && (o_count == LAST_IDX)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_done = (state_q == ST_DONE);

  // Word generation: register the current value and advance the sequence pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
      value_q <= SEED_V;
    end else begin
      o_valid <= issue;
      if (run_entry) begin
        o_count <= '0;
        value_q <= SEED_V;
      end else if (issue) begin
        o_data  <= value_q;
        value_q <= value_q + STEP_V;
        if (o_count != 32'hFFFF_FFFF) begin
          o_count <= o_count + 32'd1;
        end
      end
    end
  end

  // Credit accounting: spend on issue, refill on return, flag returns beyond capacity
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_credits    <= MAX_CREDITS;
      o_credit_err <= 1'b0;
    end else begin
      case ({issue, credit_ret})
        2'b10: o_credits <= o_credits - 1'b1;
        2'b01: begin
          if (o_credits == MAX_CREDITS) begin
            o_credit_err <= 1'b1;
          end else begin
            o_credits <= o_credits + 1'b1;
          end
        end
        default: o_credits <= o_credits;
      endcase
    end
  end

endmodule
